// File: rtl/cp0.sv
// Coprocessor-0 for the five-stage MIPS pipeline: owns SR, Cause, EPC and PRId,
// and raises Req when the M-stage instruction must be trapped.
module cp0 #(
    parameter logic [31:0] PRID = 32'h2023_0707
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    output logic [31:0] CP0Out,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic        Req
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    // Uses the live interrupt lines so latency is zero cycles, not the IP copy.
    assign int_req = sr_ie & ~sr_exl & (|(HWInt & sr_im));
    assign exc_req = ~sr_exl & (ExcCodeIn != 5'd0);
    assign Req     = ~reset & (int_req | exc_req);

    assign sr_word    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
    assign cause_word = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};
    assign EPCOut     = epc;

    always_comb begin
        CP0Out = 32'b0;
        case (CP0Add)
            ADDR_SR:    CP0Out = sr_word;
            ADDR_CAUSE: CP0Out = cause_word;
            ADDR_EPC:   CP0Out = epc;
            ADDR_PRID:  CP0Out = PRID;
            default:    CP0Out = 32'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= 6'b0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'b0;
            cause_exc <= 5'b0;
            epc       <= 32'b0;
        end else begin
            cause_ip <= HWInt;
            if (Req) begin
                // The victim is flushed, so any mtc0 or eret alongside it is dropped.
                sr_exl    <= 1'b1;
                cause_bd  <= BDIn;
                cause_exc <= int_req ? 5'd0 : ExcCodeIn;
                epc       <= BDIn ? (VPC - 32'd4) : VPC;
            end else begin
                if (en && CP0Add == ADDR_SR) begin
                    sr_im  <= CP0In[15:10];
                    sr_exl <= CP0In[1];
                    sr_ie  <= CP0In[0];
                end
                if (en && CP0Add == ADDR_EPC) begin
                    epc <= CP0In;
                end
                if (EXLClr) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 exception/interrupt controller for the five-stage MIPS pipeline. It sits beside the M stage. It owns SR, Cause, EPC and PRId, and decides each cycle whether the pipeline must trap. It drives the trap request and the return address that the next-PC logic consumes. It also accepts the `eret` return indication back from the pipeline.

## Interface
Parameters
- `PRID`, 32'h2023_0707: constant returned on reads of register 15.

Ports
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high.
- `en`, input, 1: mtc0 write enable (M stage).
- `CP0Add`, input, 5: register number for mtc0/mfc0.
- `CP0In`, input, 32: mtc0 write data.
- `CP0Out`, output, 32: mfc0 read data.
- `VPC`, input, 32: PC of the M-stage (victim) instruction.
- `BDIn`, input, 1: victim sits in a branch delay slot.
- `ExcCodeIn`, input, 5: synchronous exception code of the victim; 0 = none.
- `HWInt`, input, 6: external interrupt lines, level-sensitive.
- `EXLClr`, input, 1: `eret` retiring in M.
- `EPCOut`, output, 32: current EPC register.
- `Req`, output, 1: take trap this cycle.

## Operation
- Register 12, SR:
  - Implemented fields: IM = [15:10], EXL = [1], IE = [0].
  - All other bits read 0 and ignore writes.
- Register 13, Cause:
  - Implemented fields: BD = [31], IP = [15:10], ExcCode = [6:2].
  - All other bits read 0.
  - Cause is read-only to mtc0.
- Register 14, EPC: 32-bit, full read/write via mtc0.
- Register 15, PRId: constant `PRID`.
- Any other address: read 0, write ignored.
- IP is written every cycle with `HWInt`, so IP reflects last cycle's lines.
- Trap conditions:
  - `IntReq = IE & ~EXL & |(HWInt & IM)`, using current `HWInt`, not IP.
  - `ExcReq = ~EXL & (ExcCodeIn != 0)`.
  - `Req = IntReq | ExcReq`, combinational; forced 0 while `reset` = 1.
- When `Req` = 1 at a clock edge:
  - EXL <= 1.
  - BD <= `BDIn`.
  - ExcCode <= 0 if `IntReq`, else `ExcCodeIn`. Interrupt wins over exception.
  - EPC <= (`BDIn` ? `VPC` − 4 : `VPC`), with 32-bit wrap. For `VPC` = 0 with BD set, EPC = 32'hFFFF_FFFC.
  - Any simultaneous mtc0 write is discarded, since the victim is flushed.
  - Any simultaneous `EXLClr` is discarded.
- `EXLClr` = 1 with `Req` = 0: EXL <= 0 at the edge; no other field changes.
- mtc0 with `en` = 1 and `Req` = 0:
  - SR address: writes IM/EXL/IE from `CP0In`.
  - EPC address: writes EPC.
- Same cycle mtc0 to SR and `EXLClr`: `EXLClr` wins for EXL; IM/IE take `CP0In`.
- `CP0Out` is a combinational mux on `CP0Add`.
  - A same-cycle write is not forwarded; the old value is returned.
- `EPCOut` is the registered EPC only.
  - The hazard unit stalls `eret` in D while an mtc0 to 14 is in E/M; this block does no forwarding.
- Trap vector 32'h0000_4180 and the restart target are generated by the next-PC logic, not here.

## Timing
- `Req` is combinational from `HWInt`, `ExcCodeIn` and registered SR, valid in the same cycle.
- All register updates happen on the rising edge of `clk`.
- EXL=1 is visible from the cycle after a trap, so `Req` self-masks after one cycle. Nested traps are impossible until `eret`.
- Interrupt latency: `HWInt` asserted in cycle n with IE=1, IM set, EXL=0 gives `Req`=1 in cycle n.
- Reset (synchronous, any cycle, including a cycle with `Req` pending):
  - SR = 0, Cause = 0, EPC = 0.
  - `Req` = 0, `EPCOut` = 0.
  - `CP0Out` = 0 for addresses 12/13/14, `PRID` for 15.
  - A trap pending in a reset cycle is dropped.

## Test plan
- Reset with `HWInt`=6'h3F and `ExcCodeIn`=5'd4: `Req`=0, SR/Cause/EPC read 0, reg 15 reads `PRID`.
- Interrupt: mtc0 SR=32'h0000_0401, then `HWInt`[0]=1, `VPC`=32'h0000_3010, BD=0:
  - `Req`=1 in the same cycle.
  - Next cycle: EPC=32'h3010, Cause ExcCode=0, SR=32'h403.
  - `Req`=0 while `HWInt` is held.
- Delay-slot exception: `ExcCodeIn`=5'd12, `BDIn`=1, `VPC`=32'h0000_3024:
  - EPC=32'h3020, Cause[31]=1, ExcCode=12.
  - The simultaneous mtc0 EPC=32'hDEAD is ignored.
- Priority: IntReq and `ExcCodeIn`=5'd10 in the same cycle: ExcCode=0.
- `eret`: with EXL=1, pulse `EXLClr` → SR=32'h401 next cycle, and a pending interrupt raises `Req` that cycle.
  - `EXLClr` together with a new `ExcCodeIn`=4 while EXL=1: no trap, EXL clears.
- Masking and illegal writes:
  - IE=0 or IM=0 with `HWInt`=6'h3F: `Req`=0, and Cause IP reads 6'h3F one cycle later.
  - mtc0 to 13 leaves Cause unchanged; mtc0 to 7 reads back 0.
